// File: rtl/riot_pkg.sv
// riot_pkg: shared constants, encodings and helpers for the wb_riot_timer block.
// Optional feature macro used by the top level: RIOT_TIMER_IRQ_EN.
package riot_pkg;

    // Register offsets as seen on adr_i[4:0]
    localparam logic [4:0] TIM1T  = 5'h14;
    localparam logic [4:0] TIM8T  = 5'h15;
    localparam logic [4:0] TIM64T = 5'h16;
    localparam logic [4:0] T1024T = 5'h17;
    localparam logic [4:0] INTIM  = 5'h04;
    localparam logic [4:0] TIMINT = 5'h05;

    // Bit 3 of a load address is the irq-enable, not part of the register select
    localparam logic [4:0] LOAD_MASK = 5'b10111;
    // Reads only look at bit 2 (timer space) and bit 0 (INTIM vs TIMINT)
    localparam logic [4:0] READ_MASK = 5'b00101;

    // Divide encoding as carried by adr_i[1:0] on a timer load
    typedef enum logic [1:0] {
        DIV_1    = 2'd0,
        DIV_8    = 2'd1,
        DIV_64   = 2'd2,
        DIV_1024 = 2'd3
    } div_sel_e;

    localparam int unsigned DIV_SHIFT_1    = 0;
    localparam int unsigned DIV_SHIFT_8    = 3;
    localparam int unsigned DIV_SHIFT_64   = 6;
    localparam int unsigned DIV_SHIFT_1024 = 10;

    localparam logic [7:0] COUNTER_RESET = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ACK,
        ST_WAIT_LOW
    } bus_state_e;

    // Last prescaler value before a decrement fires: divide - 1
    function automatic logic [9:0] div_limit(div_sel_e sel);
        logic [10:0] full;
        case (sel)
            DIV_1:   full = (11'd1 << DIV_SHIFT_1) - 11'd1;
            DIV_8:   full = (11'd1 << DIV_SHIFT_8) - 11'd1;
            DIV_64:  full = (11'd1 << DIV_SHIFT_64) - 11'd1;
            default: full = (11'd1 << DIV_SHIFT_1024) - 11'd1;
        endcase
        return full[9:0];
    endfunction

    // True when a write to this offset loads the timer
    function automatic logic is_load_adr(logic [4:0] adr);
        case (adr & LOAD_MASK)
            TIM1T, TIM8T, TIM64T, T1024T: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_riot_timer_if.sv
// wb_riot_timer_if: single-beat wishbone signals between the 6502 bridge and the RIOT timer.
interface wb_riot_timer_if;
    logic       stb_i;
    logic       we_i;
    logic [6:0] adr_i;
    logic [7:0] dat_i;
    logic       ack_o;
    logic [7:0] dat_o;

    modport master (output stb_i, we_i, adr_i, dat_i, input ack_o, dat_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/riot_prescaler.sv
// riot_prescaler: 10-bit tick divider producing one decrement pulse per divide period.
// Bypass (flag set) makes every tick a decrement; force_div1 drops the divide to 1 on underflow.
module riot_prescaler
    import riot_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     tick_i,
    input  logic     load_i,
    input  div_sel_e div_sel_i,
    input  logic     force_div1_i,
    input  logic     bypass_i,
    output logic     dec_o
);

    logic [9:0] count_q, count_d;
    div_sel_e   div_sel_q, div_sel_d;
    logic [9:0] limit;

    // Decrement pulse kept apart from the next-state logic so underflow feedback stays acyclic
    assign limit = div_limit(div_sel_q);
    assign dec_o = tick_i & (bypass_i | (count_q == limit));

    // Next prescaler count and divide selection
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d   = count_q;
        div_sel_d = div_sel_q;
        if (load_i) begin
            count_d   = '0;
            div_sel_d = div_sel_i;
        end else if (tick_i) begin
            count_d = dec_o ? '0 : count_q + 10'd1;
        end
        if (force_div1_i) begin
            div_sel_d = DIV_1;
        end
    end

    // Prescaler state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            div_sel_q <= DIV_1024;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            count_q   <= count_d;
            div_sel_q <= div_sel_d;
        end
    end

endmodule

// File: rtl/wb_riot_timer.sv
// wb_riot_timer: 6532 RIOT interval timer behind a single-beat wishbone slave.
// Build option: define RIOT_TIMER_IRQ_EN to store the irq-enable bit and drive irq_o.
module wb_riot_timer
    import riot_pkg::*;
#(
    parameter int ACK_DELAY = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_riot_timer_if.slave    wb,
    input  logic              tick_i,
    output logic              irq_o
);

    bus_state_e state_q;
    logic       ack_q;
    logic [7:0] dat_q;
    logic [7:0] counter_q, counter_d;
    logic       flag_q, flag_d;

    logic [4:0] reg_adr;
    logic       accept, load, rd_intim, rd_timint;
    logic       tick_eff, dec, underflow;
    logic [7:0] rdata;
    logic       unused_adr_hi;

    assign reg_adr       = wb.adr_i[4:0];
    assign unused_adr_hi = ^wb.adr_i[6:5];

    assign accept    = (state_q == ST_IDLE) & wb.stb_i;
    assign load      = accept & wb.we_i & is_load_adr(reg_adr);
    assign rd_intim  = accept & ~wb.we_i & ((reg_adr & READ_MASK) == (INTIM & READ_MASK));
    assign rd_timint = accept & ~wb.we_i & ((reg_adr & READ_MASK) == (TIMINT & READ_MASK));

    // A load in the same clock as a tick swallows the tick
    assign tick_eff  = tick_i & ~load;
    assign underflow = dec & (counter_q == 8'h00);

    riot_prescaler u_prescaler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_i      (tick_eff),
        .load_i      (load),
        .div_sel_i   (div_sel_e'(reg_adr[1:0])),
        .force_div1_i(underflow),
        .bypass_i    (flag_q),
        .dec_o       (dec)
    );

    // Read data mux, taken from pre-tick state of the accepting clock
    always_comb begin
        rdata = 8'h00;
        if (rd_intim) begin
            rdata = counter_q;
        end else if (rd_timint) begin
            rdata = {flag_q, 7'b0};
        end
    end

    // Counter and flag next state; underflow setting the flag wins over an INTIM read clearing it
    always_comb begin
        counter_d = counter_q;
        flag_d    = flag_q;
        if (load) begin
            counter_d = wb.dat_i;
            flag_d    = 1'b0;
        end else begin
            if (rd_intim) begin
                flag_d = 1'b0;
            end
            if (dec) begin
                counter_d = counter_q - 8'd1;
            end
            if (underflow) begin
                flag_d = 1'b1;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter_q <= COUNTER_RESET;
            flag_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            flag_q    <= flag_d;
        end
    end

    // Wishbone handshake: accept, optional extra delay, one-clock ack, then wait for stb low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb.stb_i) begin
                        dat_q <= rdata;
                        if (ACK_DELAY == 1) begin
                            ack_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    ack_q   <= 1'b1;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q   <= 1'b0;
                    dat_q   <= 8'h00;
                    state_q <= ST_WAIT_LOW;
                end
                default: begin
                    if (!wb.stb_i) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;

`ifdef RIOT_TIMER_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    assign irq_en_d = load ? reg_adr[3] : irq_en_q;

    // Irq-enable captured on each load; irq_o registered from flag and enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= flag_q & irq_en_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_riot_timer.sv
// tb_wb_riot_timer: directed bench with a per-cycle behavioural model of the RIOT timer.
// Honours RIOT_TIMER_IRQ_EN for the expected irq_o.
module tb_wb_riot_timer;

    localparam int ACK_DLY = 1;
`ifdef RIOT_TIMER_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic irq;

    wb_riot_timer_if bus ();

    wb_riot_timer #(.ACK_DELAY(ACK_DLY)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .wb    (bus),
        .tick_i(tick),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        div_tab [4] = '{1, 8, 64, 1024};
    bit        acc_pending = 1'b0;
    int        m_cnt, m_div, m_pre;
    bit        m_flag, m_en;
    int        ack_cd;
    bit        exp_ack, exp_is_read, exp_irq;
    logic [7:0] exp_dat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 255; m_div = 1024; m_pre = 0; m_flag = 0; m_en = 0;
            ack_cd = 0; exp_ack = 0; exp_is_read = 0; exp_irq = 0; exp_dat = 8'h00;
            acc_pending = 0;
        end else begin
            bit prev_flag, prev_en, ack_n, do_load, do_rd, bump;
            prev_flag = m_flag;
            prev_en   = m_en;
            ack_n     = 0;
            do_load   = 0;
            do_rd     = 0;
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) ack_n = 1;
            end
            if (acc_pending) begin
                acc_pending = 0;
                exp_is_read = !bus.we_i;
                if (bus.we_i && bus.adr_i[4] && bus.adr_i[2]) do_load = 1;
                if (!bus.we_i) begin
                    if (!bus.adr_i[2]) exp_dat = 8'h00;
                    else if (bus.adr_i[0]) exp_dat = {m_flag, 7'b0};
                    else begin
                        exp_dat = m_cnt[7:0];
                        do_rd = 1;
                    end
                end
                if (ACK_DLY == 1) ack_n = 1; else ack_cd = ACK_DLY - 1;
            end
            if (do_load) begin
                m_cnt  = bus.dat_i;
                m_div  = div_tab[bus.adr_i[1:0]];
                m_pre  = 0;
                m_flag = 0;
                m_en   = bus.adr_i[3];
            end else begin
                if (do_rd) m_flag = 0;
                if (tick) begin
                    bump = prev_flag || (m_div == 1);
                    if (!bump) begin
                        m_pre++;
                        if (m_pre == m_div) begin
                            bump  = 1;
                            m_pre = 0;
                        end
                    end
                    if (bump) begin
                        if (m_cnt == 0) begin
                            m_cnt = 255; m_flag = 1; m_div = 1;
                        end else begin
                            m_cnt--;
                        end
                    end
                end
            end
            exp_irq = IRQ_BUILD && prev_flag && prev_en;
            exp_ack = ack_n;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit prev_exp_ack = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check(bus.ack_o == exp_ack, "ack_o", bus.ack_o, exp_ack);
            if (exp_ack && exp_is_read)
                check(bus.dat_o == exp_dat, "dat_o", bus.dat_o, exp_dat);
            if (prev_exp_ack)
                check(bus.dat_o == 8'h00, "dat_o_after_ack", bus.dat_o, 0);
            check(irq == exp_irq, "irq_o", irq, exp_irq);
            prev_exp_ack = exp_ack;
        end else begin
            prev_exp_ack = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_xfer(input logic we, input logic [6:0] adr, input logic [7:0] wd,
                            input logic tk, input int hold, output logic [7:0] rd);
        bit got = 0;
        rd = 8'h00;
        @(posedge clk); #1;
        bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
        tick = tk; acc_pending = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack_o) begin
                got = 1;
                rd  = bus.dat_o;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        check(got, "ack_timeout", got, 1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic wr(input logic [6:0] adr, input logic [7:0] wd, input logic tk = 1'b0);
        logic [7:0] dummy;
        bus_xfer(1'b1, adr, wd, tk, 0, dummy);
    endtask

    task automatic rd_chk(input logic [6:0] adr, input logic [7:0] exp, input string name,
                          input logic tk = 1'b0, input int hold = 0);
        logic [7:0] v;
        bus_xfer(1'b0, adr, 8'h00, tk, hold, v);
        check(v == exp, name, v, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tick = 1'b1;
        end
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        rd_chk(7'h04, 8'hFF, "reset_intim");
        rd_chk(7'h05, 8'h00, "reset_timint");

        // TIM1T underflow
        wr(7'h14, 8'h03);
        ticks(3);
        rd_chk(7'h04, 8'h00, "tim1t_3ticks");
        ticks(1);
        rd_chk(7'h05, 8'h80, "tim1t_timint");
        rd_chk(7'h04, 8'hFF, "tim1t_wrap");
        ticks(1);
        rd_chk(7'h04, 8'hFE, "tim1t_after_wrap");

        // TIM64T
        wr(7'h16, 8'h02);
        ticks(63);
        rd_chk(7'h04, 8'h02, "tim64_63");
        ticks(1);
        rd_chk(7'h04, 8'h01, "tim64_64");
        ticks(64);
        rd_chk(7'h04, 8'h00, "tim64_128");
        ticks(64);
        rd_chk(7'h05, 8'h80, "tim64_192_flag");
        rd_chk(7'h04, 8'hFF, "tim64_192");
        ticks(1);
        rd_chk(7'h04, 8'hFE, "tim64_193");

        // TIM8T
        wr(7'h15, 8'h05);
        ticks(7);
        rd_chk(7'h04, 8'h05, "tim8_7");
        ticks(1);
        rd_chk(7'h04, 8'h04, "tim8_8");

        // Clear rules
        wr(7'h14, 8'h00);
        ticks(1);
        rd_chk(7'h05, 8'h80, "clr_timint1");
        rd_chk(7'h05, 8'h80, "clr_timint2");
        rd_chk(7'h04, 8'hFF, "clr_intim");
        rd_chk(7'h05, 8'h00, "clr_timint3");

        // Load and tick in the same clock
        wr(7'h14, 8'h10, 1'b1);
        rd_chk(7'h04, 8'h10, "load_tick");

        // INTIM read coincident with underflow
        ticks(16);
        rd_chk(7'h04, 8'h00, "rd_underflow", 1'b1);
        rd_chk(7'h05, 8'h80, "rd_underflow_flag");

        // Other addresses, ignored writes, ignored upper address bits, held strobe
        rd_chk(7'h00, 8'h00, "other_read");
        wr(7'h10, 8'h55);
        rd_chk(7'h64, 8'hFF, "adr_hi_ignored", 1'b0, 3);
        rd_chk(7'h14, 8'hFF, "read_adr4_ignored");

        // IRQ
        wr(7'h1C, 8'h01);
        ticks(2);
        @(negedge clk);
        check(irq == 1'b0, "irq_before", irq, 0);
        @(posedge clk); #1;
        check(irq == IRQ_BUILD, "irq_rise", irq, IRQ_BUILD);
        wr(7'h14, 8'h20);
        check(irq == 1'b0, "irq_drop", irq, 0);

        // T1024T
        wr(7'h17, 8'h01);
        ticks(1023);
        rd_chk(7'h04, 8'h01, "t1024_1023");
        ticks(1);
        rd_chk(7'h04, 8'h00, "t1024_1024");

        // Reset in the middle of an acknowledged read
        @(posedge clk); #1;
        bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 7'h04; acc_pending = 1'b1;
        @(posedge clk); #1;
        check(bus.ack_o == 1'b1, "pre_reset_ack", bus.ack_o, 1);
        rst_n = 1'b0;
        #1;
        check(bus.ack_o == 1'b0, "reset_ack_drop", bus.ack_o, 0);
        check(bus.dat_o == 8'h00, "reset_dat", bus.dat_o, 0);
        bus.stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk(7'h04, 8'hFF, "rereset_intim");
        rd_chk(7'h05, 8'h00, "rereset_timint");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
